// File: rtl/light_shade_sequencer_pkg.sv
// Shared types, constants and helpers for the light shade sequencer and
// neighbouring shading stages.
package light_shade_sequencer_pkg;

    localparam logic [7:0] COLOR_MAX = 8'hFF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } RayDirection;

    typedef struct packed {
        Color       color;
        logic [7:0] intensity;
    } LightSource_t;

    typedef struct packed {
        logic        hit;
        logic [15:0] t;
        RayDirection normal;
        Color        color;
    } AABB_result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } shade_seq_state_e;

    // 8-bit channel add that clips at full intensity instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? COLOR_MAX : s[7:0];
    endfunction

endpackage

// File: rtl/light_shade_sequencer_if.sv
// Request/response bundle between the ray unit (master) and the sequencer (slave).
interface light_shade_sequencer_if #(
    parameter int MAX_LIGHTS = 8
);
    import light_shade_sequencer_pkg::*;

    localparam int IDX_W = $clog2(MAX_LIGHTS);

    logic         req_valid_in;
    logic         req_ready_out;
    AABB_result_t aabb_in;
    logic [IDX_W:0] num_lights_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    Color         color_out;
    logic         timeout_out;

    modport master (
        output req_valid_in, aabb_in, num_lights_in, resp_ready_in,
        input  req_ready_out, resp_valid_out, color_out, timeout_out
    );

    modport slave (
        input  req_valid_in, aabb_in, num_lights_in, resp_ready_in,
        output req_ready_out, resp_valid_out, color_out, timeout_out
    );

endinterface

// File: rtl/color_sat_add.sv
// Per-channel saturating adder for two colors; purely combinational so any
// shading stage can drop it into its datapath.
module color_sat_add
    import light_shade_sequencer_pkg::*;
(
    input  Color a_i,
    input  Color b_i,
    output Color sum_o
);

    // Clip each channel independently at full intensity.
    always_comb begin
        sum_o.r = sat_add8(a_i.r, b_i.r);
        sum_o.g = sat_add8(a_i.g, b_i.g);
        sum_o.b = sat_add8(a_i.b, b_i.b);
    end

endmodule

// File: rtl/light_shade_sequencer.sv
// Time-shares one shader across up to MAX_LIGHTS lights for a single hit,
// summing the per-light colors with saturation and returning the pixel color.
module light_shade_sequencer
    import light_shade_sequencer_pkg::*;
#(
    parameter int MAX_LIGHTS     = 8,
    parameter int IDX_W          = $clog2(MAX_LIGHTS),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    light_shade_sequencer_if.slave ray_if,
    output logic                   light_rd_en_out,
    output logic [IDX_W-1:0]       light_addr_out,
    input  LightSource_t           light_src_in,
    input  RayDirection            light_dir_in,
    output logic                   shade_start_out,
    output AABB_result_t           shade_aabb_out,
    output LightSource_t           shade_light_out,
    output RayDirection            shade_dir_out,
    input  Color                   shade_color_in,
    input  logic                   shade_valid_in
);

    localparam int CNT_W = IDX_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    shade_seq_state_e state_q;
    logic             req_ready_q;
    logic             light_rd_en_q;
    logic [IDX_W-1:0] light_addr_q;
    logic             shade_start_q;
    logic             resp_valid_q;
    logic             timeout_q;
    logic             armed_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    Color             acc_q;
    AABB_result_t     shade_aabb_q;
    LightSource_t     shade_light_q;
    RayDirection      shade_dir_q;

    Color             sum_d;
    logic [CNT_W-1:0] num_clamped_d;
    logic             last_d;
    logic             accept_d;
    logic             expire_d;

    color_sat_add u_sat_add (
        .a_i   (acc_q),
        .b_i   (shade_color_in),
        .sum_o (sum_d)
    );

    // Clamp the requested light count to the table size.
    always_comb begin
        num_clamped_d = ray_if.num_lights_in;
        if (ray_if.num_lights_in > CNT_W'(MAX_LIGHTS)) begin
            num_clamped_d = CNT_W'(MAX_LIGHTS);
        end else begin
            num_clamped_d = ray_if.num_lights_in;
        end
    end

    // A result counts only once valid has been seen low since the job was issued,
    // so a valid still high from the previous job cannot be counted twice.
    assign accept_d = shade_valid_in && armed_q;
    assign expire_d = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_d   = ({1'b0, idx_q} == (cnt_q - CNT_W'(1)));

    // Sequencer FSM: walks the lights, drives registered strobes and accumulates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            light_rd_en_q <= 1'b0;
            light_addr_q  <= '0;
            shade_start_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            timeout_q     <= 1'b0;
            armed_q       <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
            tmo_cnt_q     <= '0;
            acc_q         <= '0;
            shade_aabb_q  <= '0;
            shade_light_q <= '0;
            shade_dir_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ray_if.req_valid_in) begin
                        req_ready_q  <= 1'b0;
                        shade_aabb_q <= ray_if.aabb_in;
                        cnt_q        <= num_clamped_d;
                        acc_q        <= '0;
                        timeout_q    <= 1'b0;
                        idx_q        <= '0;
                        light_addr_q <= '0;
                        if (num_clamped_d == CNT_W'(0)) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q       <= FETCH;
                            light_rd_en_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    light_rd_en_q <= 1'b0;
                    state_q       <= LOAD;
                end
                LOAD: begin
                    shade_light_q <= light_src_in;
                    shade_dir_q   <= light_dir_in;
                    shade_start_q <= 1'b1;
                    state_q       <= ISSUE;
                end
                ISSUE: begin
                    shade_start_q <= 1'b0;
                    armed_q       <= ~shade_valid_in;
                    tmo_cnt_q     <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    armed_q <= armed_q | ~shade_valid_in;
                    if (accept_d || expire_d) begin
                        if (accept_d) begin
                            acc_q <= sum_d;
                        end else begin
                            timeout_q <= 1'b1;
                        end
                        if (last_d) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                        end else begin
                            idx_q         <= idx_q + IDX_W'(1);
                            light_addr_q  <= idx_q + IDX_W'(1);
                            light_rd_en_q <= 1'b1;
                            state_q       <= FETCH;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    if (ray_if.resp_ready_in) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    req_ready_q   <= 1'b1;
                    light_rd_en_q <= 1'b0;
                    shade_start_q <= 1'b0;
                    resp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ray_if.req_ready_out  = req_ready_q;
    assign ray_if.resp_valid_out = resp_valid_q;
    assign ray_if.color_out      = acc_q;
    assign ray_if.timeout_out    = timeout_q;
    assign light_rd_en_out       = light_rd_en_q;
    assign light_addr_out        = light_addr_q;
    assign shade_start_out       = shade_start_q;
    assign shade_aabb_out        = shade_aabb_q;
    assign shade_light_out       = shade_light_q;
    assign shade_dir_out         = shade_dir_q;

endmodule

// File: tb/tb_light_shade_sequencer.sv
// Directed bench for light_shade_sequencer with a light-table model and a
// shader model (fixed latency, optional sticky valid, optional silent job).
module tb_light_shade_sequencer;
    import light_shade_sequencer_pkg::*;

    localparam int MAX_LIGHTS = 8;
    localparam int IDX_W      = 3;
    localparam int LIMIT      = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    light_shade_sequencer_if #(.MAX_LIGHTS(MAX_LIGHTS)) ray_if ();

    logic             light_rd_en_out;
    logic [IDX_W-1:0] light_addr_out;
    LightSource_t     light_src_in = '0;
    RayDirection      light_dir_in = '0;
    logic             shade_start_out;
    AABB_result_t     shade_aabb_out;
    LightSource_t     shade_light_out;
    RayDirection      shade_dir_out;
    Color             shade_color_in = '0;
    logic             shade_valid_in = 1'b0;

    int total = 0;
    int bad   = 0;

    LightSource_t tbl_light [MAX_LIGHTS];
    RayDirection  tbl_dir   [MAX_LIGHTS];
    int shd_lat     = 10;
    bit shd_hold    = 1'b0;
    int shd_mute    = -1;
    int preload_req = 0;

    int   shd_jobs    = 0;
    int   shd_age     = 1000;
    bit   shd_pend    = 1'b0;
    Color shd_cur     = '0;
    int   preload_ack = 0;
    bit   lt_pend     = 1'b0;
    logic [IDX_W-1:0] lt_addr = '0;
    int   rd_cnt      = 0;
    int   start_cnt   = 0;
    logic [IDX_W-1:0] addr_log [512];

    light_shade_sequencer #(
        .MAX_LIGHTS(MAX_LIGHTS), .IDX_W(IDX_W), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .ray_if(ray_if),
        .light_rd_en_out(light_rd_en_out), .light_addr_out(light_addr_out),
        .light_src_in(light_src_in), .light_dir_in(light_dir_in),
        .shade_start_out(shade_start_out), .shade_aabb_out(shade_aabb_out),
        .shade_light_out(shade_light_out), .shade_dir_out(shade_dir_out),
        .shade_color_in(shade_color_in), .shade_valid_in(shade_valid_in)
    );

    always #5 clk = ~clk;

    function automatic Color mk(input int r, input int g, input int b);
        mk = '{r: 8'(r), g: 8'(g), b: 8'(b)};
    endfunction

    function automatic AABB_result_t mk_aabb(input int s);
        mk_aabb = '{hit: 1'b1, t: 16'(s * 7), normal: '{x: 16'(s), y: 16'(s + 1), z: 16'(s + 2)},
                    color: mk(s, s + 3, s + 5)};
    endfunction

    // Light table: data for a strobed address appears in the following cycle, junk otherwise.
    initial forever begin
        @(negedge clk);
        if (lt_pend) begin
            light_src_in = tbl_light[lt_addr];
            light_dir_in = tbl_dir[lt_addr];
        end else begin
            light_src_in = '1;
            light_dir_in = '1;
        end
        lt_pend = light_rd_en_out;
        lt_addr = light_addr_out;
        if (light_rd_en_out && rd_cnt < 512) begin
            addr_log[rd_cnt] = light_addr_out;
            rd_cnt++;
        end
        if (shade_start_out) start_cnt++;
    end

    // Shader: returns the issued light's color shd_lat cycles after start.
    initial forever begin
        @(negedge clk);
        if (preload_req != preload_ack) begin
            preload_ack    = preload_req;
            shd_age        = 1000;
            shd_pend       = 1'b0;
            shade_valid_in = 1'b1;
            shade_color_in = mk(200, 200, 200);
        end else begin
            if (shade_start_out) begin
                shd_age  = 0;
                shd_pend = (shd_jobs != shd_mute);
                shd_cur  = shade_light_out.color;
                shd_jobs++;
            end else if (shd_age < 1000) begin
                shd_age++;
            end
            if (shd_pend && shd_age == shd_lat) begin
                shade_valid_in = 1'b1;
                shade_color_in = shd_cur;
                shd_pend       = 1'b0;
            end else if (shd_hold && shade_valid_in && (shd_age < 2 || shd_age > shd_lat)) begin
                shade_valid_in = 1'b1;
            end else begin
                shade_valid_in = 1'b0;
            end
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input Color obs, input Color exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one request from IDLE; k = negedges after the accepting edge until resp_valid.
    task automatic do_req(input AABB_result_t aabb, input logic [IDX_W:0] n, output int k);
        @(negedge clk);
        chk_b("req_ready_idle", ray_if.req_ready_out, 1'b1);
        ray_if.aabb_in       = aabb;
        ray_if.num_lights_in = n;
        ray_if.req_valid_in  = 1'b1;
        @(negedge clk);
        ray_if.req_valid_in = 1'b0;
        chk_b("req_ready_busy", ray_if.req_ready_out, 1'b0);
        k = 1;
        while (ray_if.resp_valid_out !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        chk_b("resp_seen", ray_if.resp_valid_out, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_b({tag, "_req_ready"}, ray_if.req_ready_out, 1'b1);
        chk_b({tag, "_resp_valid"}, ray_if.resp_valid_out, 1'b0);
        chk_b({tag, "_rd_en"}, light_rd_en_out, 1'b0);
        chk_b({tag, "_start"}, shade_start_out, 1'b0);
        chk_b({tag, "_timeout"}, ray_if.timeout_out, 1'b0);
        chk_c({tag, "_color"}, ray_if.color_out, mk(0, 0, 0));
        chk_i({tag, "_addr"}, int'(light_addr_out), 0);
        chk_w({tag, "_aabb"}, 128'(shade_aabb_out), 128'(0));
        chk_w({tag, "_light"}, 128'(shade_light_out), 128'(0));
        chk_w({tag, "_dir"}, 128'(shade_dir_out), 128'(0));
    endtask

    initial begin
        int k;
        int r0;
        int s0;
        AABB_result_t a;

        ray_if.req_valid_in  = 1'b0;
        ray_if.aabb_in       = '0;
        ray_if.num_lights_in = '0;
        ray_if.resp_ready_in = 1'b1;
        for (int i = 0; i < MAX_LIGHTS; i++) begin
            tbl_light[i] = '{color: mk(i + 1, 2 * (i + 1), 3 * (i + 1)), intensity: 8'(i)};
            tbl_dir[i]   = '{x: 16'(3 * i + 1), y: 16'(-i), z: 16'(100 + i)};
        end

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;

        // Single light, 10-cycle shader.
        tbl_light[0] = '{color: mk(40, 80, 120), intensity: 8'd9};
        shd_lat = 10;
        s0 = start_cnt;
        a = mk_aabb(11);
        do_req(a, 4'd1, k);
        chk_i("one_latency", k, 14);
        chk_c("one_color", ray_if.color_out, mk(40, 80, 120));
        chk_b("one_timeout", ray_if.timeout_out, 1'b0);
        chk_w("one_aabb", 128'(shade_aabb_out), 128'(a));
        chk_w("one_light", 128'(shade_light_out), 128'(tbl_light[0]));
        chk_w("one_dir", 128'(shade_dir_out), 128'(tbl_dir[0]));
        chk_i("one_starts", start_cnt - s0, 1);

        // Three lights saturating every channel.
        for (int i = 0; i < 3; i++) tbl_light[i] = '{color: mk(100, 100, 100), intensity: 8'd1};
        shd_lat = 2;
        s0 = start_cnt;
        r0 = rd_cnt;
        do_req(mk_aabb(22), 4'd3, k);
        chk_i("sat_latency", k, 16);
        chk_c("sat_color", ray_if.color_out, mk(255, 255, 255));
        chk_i("sat_reads", rd_cnt - r0, 3);
        for (int i = 0; i < 3; i++) chk_i("sat_addr", int'(addr_log[r0 + i]), i);
        chk_i("sat_starts", start_cnt - s0, 3);

        // Count above MAX_LIGHTS clamps to all eight lights.
        for (int i = 0; i < MAX_LIGHTS; i++)
            tbl_light[i] = '{color: mk(i + 1, 2 * (i + 1), 3 * (i + 1)), intensity: 8'd1};
        shd_lat = 1;
        s0 = start_cnt;
        r0 = rd_cnt;
        do_req(mk_aabb(33), 4'd12, k);
        chk_i("clamp_latency", k, 33);
        chk_c("clamp_color", ray_if.color_out, mk(36, 72, 108));
        chk_i("clamp_reads", rd_cnt - r0, 8);
        for (int i = 0; i < MAX_LIGHTS; i++) chk_i("clamp_addr", int'(addr_log[r0 + i]), i);
        chk_i("clamp_starts", start_cnt - s0, 8);

        // Second of two lights never answers.
        tbl_light[0] = '{color: mk(10, 20, 30), intensity: 8'd1};
        tbl_light[1] = '{color: mk(50, 50, 50), intensity: 8'd1};
        shd_lat  = 4;
        shd_mute = shd_jobs + 1;
        do_req(mk_aabb(44), 4'd2, k);
        chk_i("tmo_latency", k, 75);
        chk_b("tmo_flag", ray_if.timeout_out, 1'b1);
        chk_c("tmo_color", ray_if.color_out, mk(10, 20, 30));
        @(negedge clk);
        chk_b("tmo_back_idle", ray_if.req_ready_out, 1'b1);
        chk_b("tmo_resp_drop", ray_if.resp_valid_out, 1'b0);
        shd_mute = -1;

        // Zero lights: immediate black response, no table or shader traffic.
        s0 = start_cnt;
        r0 = rd_cnt;
        a = mk_aabb(55);
        do_req(a, 4'd0, k);
        chk_i("zero_latency", k, 1);
        chk_c("zero_color", ray_if.color_out, mk(0, 0, 0));
        chk_b("zero_timeout", ray_if.timeout_out, 1'b0);
        chk_i("zero_reads", rd_cnt - r0, 0);
        chk_i("zero_starts", start_cnt - s0, 0);
        chk_w("zero_aabb", 128'(shade_aabb_out), 128'(a));

        // Shader valid stuck high from before: each light counted once.
        tbl_light[0] = '{color: mk(30, 40, 50), intensity: 8'd1};
        tbl_light[1] = '{color: mk(60, 70, 80), intensity: 8'd1};
        shd_lat  = 3;
        shd_hold = 1'b1;
        preload_req++;
        repeat (2) @(negedge clk);
        s0 = start_cnt;
        do_req(mk_aabb(66), 4'd2, k);
        chk_i("stale_latency", k, 13);
        chk_c("stale_color", ray_if.color_out, mk(90, 110, 130));
        chk_i("stale_starts", start_cnt - s0, 2);
        shd_hold = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while waiting on the shader; late shader output must be ignored.
        ray_if.resp_ready_in = 1'b0;
        tbl_light[0] = '{color: mk(70, 70, 70), intensity: 8'd1};
        shd_lat = 10;
        @(negedge clk);
        ray_if.aabb_in       = mk_aabb(77);
        ray_if.num_lights_in = 4'd2;
        ray_if.req_valid_in  = 1'b1;
        @(negedge clk);
        ray_if.req_valid_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk_b("late_ready", ray_if.req_ready_out, 1'b1);
        chk_b("late_resp", ray_if.resp_valid_out, 1'b0);

        tbl_light[0] = '{color: mk(5, 6, 7), intensity: 8'd1};
        shd_lat = 3;
        do_req(mk_aabb(88), 4'd1, k);
        chk_i("post_latency", k, 7);
        chk_c("post_color", ray_if.color_out, mk(5, 6, 7));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_c("hold_color", ray_if.color_out, mk(5, 6, 7));
            chk_b("hold_valid", ray_if.resp_valid_out, 1'b1);
        end
        ray_if.resp_ready_in = 1'b1;
        @(negedge clk);
        chk_b("release_resp", ray_if.resp_valid_out, 1'b0);
        chk_b("release_ready", ray_if.req_ready_out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
